// File: rtl/bcd_display_ctrl.sv
// Binary-to-BCD display sequencer: accepts a value over valid/ready, converts it
// with a sequential double-dabble engine, and commits legal 0-9 digits plus blanking enables.
module bcd_display_ctrl #(
  parameter int BIN_W  = 10,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [BIN_W-1:0]      in_data,
  input  logic                  blank_lz,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic [DIGITS-1:0]     digit_en,
  output logic                  done,
  output logic                  overflow
);

  localparam int BW = 4 * DIGITS;
  localparam int SW = BW + BIN_W;
  localparam int CW = $clog2(BIN_W + 1);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] CONVERT = 2'd1;
  localparam logic [1:0] COMMIT  = 2'd2;

  function automatic logic [63:0] max_value(input int d);
    logic [63:0] v;
    v = 64'd1;
    for (int i = 0; i < d; i++) v = v * 64'd10;
    return v - 64'd1;
  endfunction

  localparam logic [63:0] MAX_VAL = max_value(DIGITS);

  logic [1:0]        state;
  logic [SW-1:0]     scratch;
  logic [SW-1:0]     adjusted;
  logic [CW-1:0]     cnt;
  logic              blank_q;
  logic              ovf_q;
  logic [BW-1:0]     digits;
  logic [DIGITS-1:0] en_blank;

  assign in_ready = (state == IDLE) && !reset;
  assign digits   = scratch[SW-1:BIN_W];

  // NOTE: every always_comb output gets a full default first so no latch is inferred.
  always_comb begin
    adjusted = scratch;
    for (int i = 0; i < DIGITS; i++) begin
      if (scratch[BIN_W+4*i +: 4] >= 4'd5)
        adjusted[BIN_W+4*i +: 4] = scratch[BIN_W+4*i +: 4] + 4'd3;
    end
  end

  // A digit is shown if it is the units digit or anything at or above it is nonzero.
  always_comb begin
    en_blank = '0;
    for (int i = 0; i < DIGITS; i++)
      en_blank[i] = (i == 0) || (|(digits >> (4 * i)));
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      bcd_out  <= '0;
      digit_en <= DIGITS'(1);
      done     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE:    if (in_valid) state <= CONVERT;
        CONVERT: if (cnt == CW'(1)) state <= COMMIT;
        COMMIT: begin
          state    <= IDLE;
          done     <= 1'b1;
          overflow <= ovf_q;
          if (ovf_q) begin
            bcd_out  <= {DIGITS{4'h9}};
            digit_en <= '1;
          end else begin
            bcd_out  <= digits;
            digit_en <= blank_q ? en_blank : '1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // NOTE: the conversion scratch is always loaded before use, so it carries no reset.
  always_ff @(posedge clk) begin
    if (state == IDLE && in_valid) begin
      scratch <= {{BW{1'b0}}, in_data};
      cnt     <= CW'(BIN_W);
      blank_q <= blank_lz;
      ovf_q   <= 64'(in_data) > MAX_VAL;
    end else if (state == CONVERT) begin
      scratch <= {adjusted[SW-2:0], 1'b0};
      cnt     <= cnt - CW'(1);
    end
  end

endmodule

// File: tb/tb_bcd_display_ctrl.sv
// Self-checking bench for bcd_display_ctrl: a 4-digit and a 3-digit instance
// checked against a decimal-arithmetic reference model.
module tb_bcd_display_ctrl;

  localparam int BIN_W = 10;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        in_valid, in_ready, blank_lz, done, overflow;
  logic [9:0]  in_data;
  logic [15:0] bcd_out;
  logic [3:0]  digit_en;

  logic        in_valid3, in_ready3, blank_lz3, done3, overflow3;
  logic [9:0]  in_data3;
  logic [11:0] bcd_out3;
  logic [2:0]  digit_en3;

  int  checks = 0;
  int  errors = 0;
  bit  mon_en = 1'b0;

  bcd_display_ctrl #(.BIN_W(BIN_W), .DIGITS(4)) u_dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .blank_lz(blank_lz), .bcd_out(bcd_out),
    .digit_en(digit_en), .done(done), .overflow(overflow));

  bcd_display_ctrl #(.BIN_W(BIN_W), .DIGITS(3)) u_dut3 (
    .clk(clk), .reset(reset), .in_valid(in_valid3), .in_ready(in_ready3),
    .in_data(in_data3), .blank_lz(blank_lz3), .bcd_out(bcd_out3),
    .digit_en(digit_en3), .done(done3), .overflow(overflow3));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
      $error("%s observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int pow10(input int d);
    int v = 1;
    for (int i = 0; i < d; i++) v = v * 10;
    return v;
  endfunction

  // Reference: decimal digits by division; saturate to all nines when too large.
  function automatic logic [31:0] ref_bcd(input int v, input int nd);
    logic [31:0] r = '0;
    for (int i = 0; i < nd; i++)
      r[4*i +: 4] = (v >= pow10(nd)) ? 4'd9 : 4'((v / pow10(i)) % 10);
    return r;
  endfunction

  function automatic logic [31:0] ref_en(input int v, input bit blz, input int nd);
    int top = 0;
    logic [31:0] r = '0;
    if (v >= pow10(nd) || !blz) return (32'd1 << nd) - 32'd1;
    for (int i = 0; i < nd; i++) if (v >= pow10(i)) top = i;
    for (int i = 0; i <= top; i++) r[i] = 1'b1;
    return r;
  endfunction

  // Every seg7 input must be a legal 0-9 code on every cycle.
  always @(negedge clk) begin
    if (mon_en) begin
      for (int i = 0; i < 4; i++) check("nibble_le9_d4", 32'(bcd_out[4*i +: 4] <= 4'd9), 32'd1);
      for (int i = 0; i < 3; i++) check("nibble_le9_d3", 32'(bcd_out3[4*i +: 4] <= 4'd9), 32'd1);
    end
  end

  task automatic run(input bit d3, input int value, input bit blz, input string tag);
    int k;
    int nd = d3 ? 3 : 4;
    if (d3) begin in_valid3 = 1'b1; in_data3 = 10'(value); blank_lz3 = blz; end
    else    begin in_valid  = 1'b1; in_data  = 10'(value); blank_lz  = blz; end
    k = 0;
    while (!(d3 ? in_ready3 : in_ready) && k < 50) begin @(posedge clk); #1; k++; end
    check({tag, "_ready"}, 32'(d3 ? in_ready3 : in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; in_valid3 = 1'b0;
    k = 0;
    do begin @(posedge clk); #1; k++; end while (!(d3 ? done3 : done) && k < 50);
    check({tag, "_latency"}, 32'(k), 32'(BIN_W + 1));
    check({tag, "_bcd"}, d3 ? 32'(bcd_out3) : 32'(bcd_out), ref_bcd(value, nd));
    check({tag, "_en"}, d3 ? 32'(digit_en3) : 32'(digit_en), ref_en(value, blz, nd));
    check({tag, "_ovf"}, 32'(d3 ? overflow3 : overflow), 32'(value >= pow10(nd)));
  endtask

  initial begin
    int k, lowcnt, v;
    bit b;
    reset = 1'b1; in_valid = 1'b0; in_data = '0; blank_lz = 1'b0;
    in_valid3 = 1'b0; in_data3 = '0; blank_lz3 = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 32'(in_ready), 32'd0);
    check("rst_bcd", 32'(bcd_out), 32'h0);
    check("rst_en", 32'(digit_en), 32'h1);
    check("rst_done", 32'(done), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    mon_en = 1'b1;
    reset = 1'b0;
    #1;
    check("rst_release_ready", 32'(in_ready), 32'd1);

    // Directed cases
    run(1'b0, 0, 1'b1, "zero_blank");
    run(1'b0, 1023, 1'b1, "max_in");
    run(1'b0, 57, 1'b1, "v57_blank");
    run(1'b0, 57, 1'b0, "v57_noblank");
    run(1'b1, 1000, 1'b1, "d3_ovf");
    run(1'b1, 999, 1'b1, "d3_max");
    run(1'b1, 0, 1'b0, "d3_zero_noblank");

    // Back-to-back with in_valid held: 5 then 6
    in_valid = 1'b1; in_data = 10'd5; blank_lz = 1'b0;
    k = 0;
    while (!in_ready && k < 50) begin @(posedge clk); #1; k++; end
    @(posedge clk); #1;
    in_data = 10'd6;
    lowcnt = 0; k = 0;
    while (!done && k < 50) begin
      if (!in_ready) lowcnt++;
      @(posedge clk); #1; k++;
    end
    check("b2b_busy_cycles", 32'(lowcnt), 32'd11);
    check("b2b_first_bcd", 32'(bcd_out), 32'h0005);
    check("b2b_ready_at_done", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    check("b2b_done_pulse", 32'(done), 32'd0);
    check("b2b_second_taken", 32'(in_ready), 32'd0);
    in_valid = 1'b0;
    k = 0;
    do begin @(posedge clk); #1; k++; end while (!done && k < 50);
    check("b2b_second_latency", 32'(k), 32'd11);
    check("b2b_second_bcd", 32'(bcd_out), 32'h0006);
    repeat (3) begin
      @(posedge clk); #1;
      check("b2b_no_dup", 32'(done), 32'd0);
      check("b2b_hold_bcd", 32'(bcd_out), 32'h0006);
    end

    // Randomized values against the reference model
    for (int n = 0; n < 20; n++) begin
      v = int'($urandom_range(0, 1023));
      b = 1'($urandom % 2);
      run(1'b0, v, b, "rand_d4");
      v = int'($urandom_range(0, 1023));
      b = 1'($urandom % 2);
      run(1'b1, v, b, "rand_d3");
    end

    // Reset in the middle of a conversion
    run(1'b0, 321, 1'b1, "pre_abort");
    in_valid = 1'b1; in_data = 10'd789; blank_lz = 1'b1;
    k = 0;
    while (!in_ready && k < 50) begin @(posedge clk); #1; k++; end
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("abort_ready_low", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    check("abort_bcd", 32'(bcd_out), 32'h0);
    check("abort_en", 32'(digit_en), 32'h1);
    check("abort_done", 32'(done), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    check("abort_ready_after", 32'(in_ready), 32'd1);
    repeat (14) begin
      @(posedge clk); #1;
      check("abort_no_done", 32'(done), 32'd0);
      check("abort_hold_bcd", 32'(bcd_out), 32'h0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
